// File: rtl/pcm_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pcm_capture_ctrl_if
//  Purpose  : Bundles the PCM sample stream, the firmware control/response
//             PIO pair and the Avalon-MM write port of the PCM memory.
//  Modports : master - the capture controller (consumes samples and control,
//                      drives response and memory writes)
//             slave  - the environment side (sample source, firmware PIO,
//                      PCM memory)
//  Revision : 1.0 - initial release
// ============================================================================
interface pcm_capture_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic                  pcm_valid;
    logic [DATA_W-1:0]     pcm_data;
    logic [3:0]            pccm_ctl;
    logic [3:0]            pccm_rsp;
    logic [ADDR_W-1:0]     mem_address;
    logic                  mem_chipselect;
    logic                  mem_clken;
    logic                  mem_write;
    logic [DATA_W-1:0]     mem_writedata;
    logic [DATA_W/8-1:0]   mem_byteenable;

    modport master (
        input  pcm_valid, pcm_data, pccm_ctl,
        output pccm_rsp, mem_address, mem_chipselect, mem_clken,
               mem_write, mem_writedata, mem_byteenable
    );

    modport slave (
        output pcm_valid, pcm_data, pccm_ctl,
        input  pccm_rsp, mem_address, mem_chipselect, mem_clken,
               mem_write, mem_writedata, mem_byteenable
    );
endinterface
`default_nettype wire

// File: rtl/pcm_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pcm_capture_ctrl
//  Purpose  : Writes a free-running PCM sample stream into a ping-pong pair of
//             halves of the PCM memory and handshakes each completed half with
//             firmware through the control/response PIO pair.
//  Ports    : clk_clk      - system clock
//             reset_reset  - asynchronous active-high reset
//             bus          - pcm_capture_ctrl_if.master (sample stream,
//                            pccm_ctl in, pccm_rsp out, Avalon-MM write port)
//  Revision : 1.0 - initial release
// ============================================================================
module pcm_capture_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  wire                   clk_clk,
    input  wire                   reset_reset,
    pcm_capture_ctrl_if.master    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]          half_ready_q, half_ready_d;
    logic                overflow_q, overflow_d;
    // Only the edge-triggered control bits need a history; run is a level.
    logic [3:1]          ctl_q;
    logic [3:0]          rsp_q, rsp_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                run;
    logic [3:1]          rise;
    logic                cur_half;
    logic                at_half_start;
    logic                at_half_end;
    logic [1:0]          half_set;

    assign run           = bus.pccm_ctl[0];
    assign rise          = bus.pccm_ctl[3:1] & ~ctl_q;
    assign cur_half      = wr_ptr_q[ADDR_W-1];
    assign at_half_start = (wr_ptr_q[ADDR_W-2:0] == '0);
    assign at_half_end   = &wr_ptr_q[ADDR_W-2:0];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        half_ready_d = half_ready_q;
        overflow_d   = overflow_q;
        wr_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        half_set     = 2'b00;

        if (rise[1]) begin
            // Clear overrides everything, including a sample in this cycle.
            wr_ptr_d     = '0;
            half_ready_d = 2'b00;
            overflow_d   = 1'b0;
            state_d      = run ? ST_FILL : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Resuming onto the start of a half firmware still owns.
                    if (run) begin
                        state_d = (at_half_start && half_ready_q[cur_half])
                                  ? ST_STALL : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (bus.pcm_valid) begin
                        wr_d     = 1'b1;
                        addr_d   = wr_ptr_q;
                        wdata_d  = bus.pcm_data;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (at_half_end) begin
                            half_set = cur_half ? 2'b10 : 2'b01;
                            if (half_ready_q[~cur_half]) begin
                                state_d = ST_STALL;
                            end
                        end
                    end
                    if (!run) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (bus.pcm_valid) begin
                        overflow_d = 1'b1;
                    end
                    // wr_ptr already points at the first word of the awaited half.
                    if (!half_ready_q[cur_half]) begin
                        state_d = ST_FILL;
                    end
                    if (!run) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // A completing half wins over a simultaneous ack of that half.
            half_ready_d = (half_ready_q & ~rise[3:2]) | half_set;
        end

        // Response lags the flags by one cycle so a half_ready bit is only
        // seen once its last word has been captured by the RAM.
        rsp_d = {overflow_q, half_ready_q, (state_q != ST_IDLE)};
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            half_ready_q <= 2'b00;
            overflow_q   <= 1'b0;
            ctl_q        <= '0;
            rsp_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            half_ready_q <= half_ready_d;
            overflow_q   <= overflow_d;
            ctl_q        <= bus.pccm_ctl[3:1];
            rsp_q        <= rsp_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.pccm_rsp       = rsp_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_writedata  = wdata_q;
    assign bus.mem_chipselect = wr_q;
    assign bus.mem_clken      = wr_q;
    assign bus.mem_write      = wr_q;
    assign bus.mem_byteenable = {(DATA_W/8){wr_q}};

endmodule
`default_nettype wire

// File: tb/tb_pcm_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcm_capture_ctrl
//  Purpose  : Self-checking bench for pcm_capture_ctrl. A sample-level model
//             predicts where each accepted sample lands and the firmware
//             visible flags; a monitor records every write the RAM captures.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pcm_capture_ctrl;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int HALF   = 1 << (ADDR_W - 1);
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk_clk     = 1'b0;
    logic reset_reset = 1'b1;

    pcm_capture_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pcm_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus)
    );

    always #5 clk_clk = ~clk_clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  strobe_bad = 0;

    // Memory-side monitor: what the RAM captures at each edge.
    always @(posedge clk_clk) begin
        if (bus.mem_write) begin
            obs_q.push_back({bus.mem_address, bus.mem_writedata});
            if (!(bus.mem_chipselect && bus.mem_clken && bus.mem_byteenable == 2'b11))
                strobe_bad++;
        end
    end

    // Sample-level model state.
    int   m_ptr;
    bit   m_ready[2];
    bit   m_ovf;
    bit   m_run;

    task automatic model_reset();
        m_ptr = 0; m_ready[0] = 0; m_ready[1] = 0; m_ovf = 0;
    endtask

    // A sample lands at the next word unless that word starts a half still
    // owned by firmware, in which case it is lost and flagged.
    task automatic model_sample(input logic [DATA_W-1:0] d);
        int h;
        if (!m_run) return;
        h = (m_ptr / HALF) % 2;
        if ((m_ptr % HALF) == 0 && m_ready[h]) begin
            m_ovf = 1;
            return;
        end
        exp_q.push_back({m_ptr[ADDR_W-1:0], d});
        if ((m_ptr % HALF) == HALF - 1) m_ready[h] = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
    endtask

    function automatic logic [3:0] exp_rsp();
        return {m_ovf, m_ready[1], m_ready[0], m_run};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // mode 0: data = running index, mode 1: random data
    task automatic send(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            bus.pcm_valid = 1'b1;
            bus.pcm_data  = (mode == 0) ? DATA_W'(i) : DATA_W'($urandom);
            model_sample(bus.pcm_data);
            tick();
        end
        bus.pcm_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int n;
        int mism;
        tick();
        tick();
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        mism = 0;
        for (int i = 0; i < n; i++)
            if (obs_q[i] !== exp_q[i]) mism++;
        chk({tag, "_mismatches"}, mism, 0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit v;
        bus.pcm_valid = 1'b0;
        bus.pcm_data  = '0;
        bus.pccm_ctl  = 4'b0000;
        model_reset();
        m_run = 0;

        // Reset state
        #12;
        chk("reset_rsp", bus.pccm_rsp, 4'b0000);
        chk("reset_strobes", {bus.mem_chipselect, bus.mem_clken, bus.mem_write, bus.mem_byteenable}, 0);
        chk("reset_addr", bus.mem_address, 0);
        @(negedge clk_clk);
        reset_reset = 1'b0;

        // Reset during FILL
        bus.pccm_ctl = 4'b0001; m_run = 1;
        tick(); tick();
        send(5, 1);
        chk("pre_reset_strobe", bus.mem_write, 1);
        reset_reset = 1'b1;
        #1;
        chk("async_reset_strobes", {bus.mem_chipselect, bus.mem_clken, bus.mem_write, bus.mem_byteenable}, 0);
        chk("async_reset_rsp", bus.pccm_rsp, 4'b0000);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        obs_q.delete(); exp_q.delete();
        model_reset();
        tick(); tick();

        // First half fill, data = index, starting at address 0 after reset
        send(HALF, 0);
        chk("flag_not_before_capture", bus.pccm_rsp, 4'b0001);
        tick();
        chk("half0_ready", bus.pccm_rsp, exp_rsp());
        check_writes("half0");

        // Second half with random gaps, then 3 samples into a full buffer
        acc = 0;
        while (acc < HALF) begin
            v = 1'($urandom_range(0, 1));
            bus.pcm_valid = v;
            bus.pcm_data  = DATA_W'($urandom);
            if (v) begin
                model_sample(bus.pcm_data);
                acc++;
            end
            tick();
        end
        bus.pcm_valid = 1'b0;
        tick(); tick();
        chk("both_ready", bus.pccm_rsp, exp_rsp());
        send(3, 1);
        tick(); tick();
        chk("stall_overflow", bus.pccm_rsp, exp_rsp());
        check_writes("half1");

        // Ack half 0 releases the stall; wrap back to address 0
        bus.pccm_ctl = 4'b0101;
        m_ready[0] = 0;
        tick(); tick();
        chk("ack_rsp", bus.pccm_rsp, exp_rsp());
        bus.pcm_valid = 1'b1;
        bus.pcm_data  = 16'hBEEF;
        model_sample(bus.pcm_data);
        tick();
        bus.pcm_valid = 1'b0;
        chk("beef_strobe", bus.mem_write, 1);
        chk("beef_addr", bus.mem_address, 0);
        chk("beef_data", bus.mem_writedata, 16'hBEEF);
        check_writes("ack");

        // Clear with both flags and overflow set; sample in the clear cycle is lost
        bus.pccm_ctl  = 4'b0011;
        bus.pcm_valid = 1'b1;
        bus.pcm_data  = DATA_W'($urandom);
        model_reset();
        tick();
        bus.pcm_valid = 1'b0;
        bus.pccm_ctl  = 4'b0001;
        tick();
        chk("clear_rsp", bus.pccm_rsp, exp_rsp());

        // Pause after 10 samples, 5 ignored samples, resume at address 10
        send(10, 1);
        bus.pccm_ctl = 4'b0000; m_run = 0;
        tick();
        send(5, 1);
        chk("pause_rsp", bus.pccm_rsp, exp_rsp());
        bus.pccm_ctl = 4'b0001; m_run = 1;
        tick();
        send(1, 1);
        chk("resume_addr", bus.mem_address, 10);
        check_writes("pause");

        // Ack of half 0 in the same cycle as its last word: flag stays set
        send(HALF - 12, 1);
        bus.pccm_ctl  = 4'b0101;
        bus.pcm_valid = 1'b1;
        bus.pcm_data  = DATA_W'($urandom);
        model_sample(bus.pcm_data);
        tick();
        bus.pcm_valid = 1'b0;
        bus.pccm_ctl  = 4'b0001;
        tick();
        chk("collision_flag", bus.pccm_rsp, exp_rsp());
        check_writes("collision");

        chk("strobe_consistency", strobe_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
